neuron_mac_seq: RTL and testbench
=================================

// Module: neuron_mac_seq
// PURPOSE
//  Parametrised N-input neuron: out = ReLU(sum_i x[i]*w[i] + bias), computed on one
//  time-multiplexed multiply-accumulate unit. It replaces the fixed 3-input neurons
//  in the MLP layers and sits between layer activations and the next layer.
//  Valid/ready handshakes on input and output let layers chain with backpressure.
// PARAMETERS
//  N_INPUTS  3   number of inputs/weights, >=1
//  IN_W      10  activation width, unsigned
//  WT_W      8   weight and bias width, signed two's complement
//  OUT_W     11  output width, unsigned (post-ReLU)
//  ACC_W     24  accumulator width, signed; must be >= IN_W+WT_W+2+clog2(N_INPUTS)
// PORTS
//  clk         in   1              clock, all logic on posedge
//  rst         in   1              synchronous reset, active-high
//  in_valid    in   1              x_in/w_in/bias_in valid
//  in_ready    out  1              block can accept a new operand set
//  x_in        in   N_INPUTS*IN_W  activations; x[i] = x_in[i*IN_W +: IN_W]
//  w_in        in   N_INPUTS*WT_W  weights; w[i] = w_in[i*WT_W +: WT_W], signed
//  bias_in     in   WT_W           bias, signed
//  out_valid   out  1              neuron_out holds a result
//  out_ready   in   1              downstream accepts the result
//  neuron_out  out  OUT_W          activated result
// BEHAVIOUR
//  - Reset: rst is synchronous, active-high; clock is clk. On reset: state=IDLE,
//    in_ready=1, out_valid=0, neuron_out=0, acc=0, idx=0. Reset takes priority in
//    every state and discards any partial accumulation.
//  - FSM IDLE -> MAC -> OUT -> IDLE.
//  - IDLE: in_ready=1. If in_valid, register x, w and bias, set acc = sext(bias),
//    set idx=0, go to MAC. Inputs are not sampled again until the next IDLE accept.
//  - MAC: in_ready=0. Each cycle acc += zext(x[idx]) * sext(w[idx]) (signed), then
//    idx++. After the product for idx=N_INPUTS-1, load neuron_out and go to OUT.
//  - OUT: out_valid=1. neuron_out is stable while out_valid && !out_ready.
//    On out_ready go to IDLE, clear out_valid, and hold neuron_out at its last value.
//  - Latency: accept edge to out_valid=1 is N_INPUTS+1 cycles.
//  - Throughput: at most one result per N_INPUTS+2 cycles. in_ready is 0 in the
//    cycle the result is taken, so no same-cycle accept-and-retire.
//  - Activation: acc <= 0 -> 0 (the zero case is included).
//    0 < acc <= 2^OUT_W-1 -> acc[OUT_W-1:0].
//  - Overflow (acc > 2^OUT_W-1) is governed by CONFIGURATION.
//  - x=0 or w=0 are ordinary operands. The MAC phase always runs N_INPUTS cycles;
//    there is no early exit.
// CONFIGURATION
//  NEURON_SAT_EN defined: acc > 2^OUT_W-1 drives neuron_out = all ones (2^OUT_W-1).
//  NEURON_SAT_EN undefined: positive acc is truncated to acc[OUT_W-1:0] (wraps).
//  Negative acc gives 0 in both builds.
// TESTING (N_INPUTS=3, IN_W=10, WT_W=8, OUT_W=11)
//  1. x=(1,2,3), w=(1,1,1), b=0, in_valid 1 cycle -> out_valid after 4 cycles,
//     neuron_out=6.
//  2. x=(5,5,5), w=(-1,-1,-1), b=0 -> neuron_out=0.
//     x=(10,0,0), w=(2,0,0): b=-25 -> 0; b=-15 -> 5.
//  3. x=(1023,1023,1023), w=(127,127,127), b=127 -> acc=389890.
//     With NEURON_SAT_EN -> 2047; without -> 770.
//  4. out_ready=0 for 5 cycles in OUT -> out_valid and neuron_out held, in_ready=0.
//     out_ready=1 -> next cycle in_ready=1 and out_valid=0.
//  5. Assert rst on the 2nd MAC cycle -> next cycle in_ready=1, out_valid=0,
//     neuron_out=0. A fresh test-1 transaction afterwards gives 6.
//  6. Back-to-back: in_valid held high, out_ready=1, 4 operand sets.
//     -> 4 correct results, one per 5 cycles; x/w changes during MAC are ignored.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// N-input ReLU neuron computed on a single time-multiplexed multiply-accumulate unit.
// Define NEURON_SAT_EN to saturate positive overflow to all ones instead of wrapping.
module neuron_mac_seq #(
  parameter int N_INPUTS = 3,
  parameter int IN_W     = 10,
  parameter int WT_W     = 8,
  parameter int OUT_W    = 11,
  parameter int ACC_W    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_INPUTS*IN_W-1:0] x_in,
  input  logic [N_INPUTS*WT_W-1:0] w_in,
  input  logic [WT_W-1:0]          bias_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         neuron_out
);

  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;

  state_t                         state_q, state_d;
  logic [N_INPUTS-1:0][IN_W-1:0]  x_q, x_d;
  logic [N_INPUTS-1:0][WT_W-1:0]  w_q, w_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [OUT_W-1:0]               out_q, out_d;

  logic signed [IN_W:0]           x_ext;
  logic signed [WT_W-1:0]         w_sel;
  logic signed [IN_W+WT_W:0]      prod;
  logic signed [ACC_W-1:0]        acc_sum;
  logic [OUT_W-1:0]               act;

  // Activations are unsigned, so a zero MSB is prepended before the signed multiply.
  always_comb begin
    x_ext   = $signed({1'b0, x_q[idx_q]});
    w_sel   = $signed(w_q[idx_q]);
    prod    = x_ext * w_sel;
    acc_sum = acc_q + $signed({{(ACC_W-IN_W-WT_W-1){prod[IN_W+WT_W]}}, prod});
  end

  always_comb begin
    act = '0;
    if (!acc_sum[ACC_W-1] && (acc_sum != '0)) begin
`ifdef NEURON_SAT_EN
      if (|acc_sum[ACC_W-2:OUT_W]) begin
        act = '1;
      end else begin
        act = acc_sum[OUT_W-1:0];
      end
`else
      act = acc_sum[OUT_W-1:0];
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    w_d       = w_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = x_in;
          w_d     = w_in;
          acc_d   = $signed({{(ACC_W-WT_W){bias_in[WT_W-1]}}, bias_in});
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          out_d   = act;
          idx_d   = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset wins in every state and throws away any partial accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

  assign neuron_out = out_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: directed corner cases plus randomized traffic with
// random backpressure, checked against an arithmetic reference model.
module tb_neuron_mac_seq;

  localparam int N_INPUTS = 3;
  localparam int IN_W     = 10;
  localparam int WT_W     = 8;
  localparam int OUT_W    = 11;
  localparam int ACC_W    = 24;
  localparam longint OUT_MAXV = (64'sd1 <<< OUT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [N_INPUTS*IN_W-1:0] x_in = '0;
  logic [N_INPUTS*WT_W-1:0] w_in = '0;
  logic [WT_W-1:0]          bias_in = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [OUT_W-1:0]         neuron_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_accept_cyc = 0;
  logic [OUT_W-1:0] sb_q[$];

  neuron_mac_seq #(
    .N_INPUTS(N_INPUTS), .IN_W(IN_W), .WT_W(WT_W), .OUT_W(OUT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_in(w_in), .bias_in(bias_in),
    .out_valid(out_valid), .out_ready(out_ready), .neuron_out(neuron_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer dot product, bias, then ReLU with overflow policy.
  function automatic logic [OUT_W-1:0] ref_neuron(input logic [N_INPUTS*IN_W-1:0] xv,
                                                  input logic [N_INPUTS*WT_W-1:0] wv,
                                                  input logic [WT_W-1:0] b);
    longint acc;
    longint xi;
    longint wi;
    longint r;
    acc = longint'($signed(b));
    for (int i = 0; i < N_INPUTS; i++) begin
      xi  = longint'(xv[i*IN_W +: IN_W]);
      wi  = longint'($signed(wv[i*WT_W +: WT_W]));
      acc = acc + xi * wi;
    end
    if (acc <= 0) r = 0;
    else if (acc > OUT_MAXV) begin
`ifdef NEURON_SAT_EN
      r = OUT_MAXV;
`else
      r = acc % (OUT_MAXV + 1);
`endif
    end else r = acc;
    return OUT_W'(r);
  endfunction

  function automatic logic [N_INPUTS*IN_W-1:0] pack_x(input int a, input int b, input int c);
    logic [N_INPUTS*IN_W-1:0] v;
    v = '0;
    v[0*IN_W +: IN_W] = IN_W'(a);
    v[1*IN_W +: IN_W] = IN_W'(b);
    v[2*IN_W +: IN_W] = IN_W'(c);
    return v;
  endfunction

  function automatic logic [N_INPUTS*WT_W-1:0] pack_w(input int a, input int b, input int c);
    logic [N_INPUTS*WT_W-1:0] v;
    v = '0;
    v[0*WT_W +: WT_W] = WT_W'(a);
    v[1*WT_W +: WT_W] = WT_W'(b);
    v[2*WT_W +: WT_W] = WT_W'(c);
    return v;
  endfunction

  function automatic int rand_x();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 1023;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  function automatic int rand_w();
    case ($urandom_range(0, 4))
      0: return -128;
      1: return 127;
      2: return 0;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: a result leaves the DUT whenever out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_result", longint'(neuron_out), -1);
      end else begin
        check_output("result", longint'(neuron_out), longint'(sb_q.pop_front()));
      end
    end
  end

  task automatic apply_stimulus(input logic [N_INPUTS*IN_W-1:0] xv,
                                input logic [N_INPUTS*WT_W-1:0] wv,
                                input logic [WT_W-1:0] b,
                                input bit hold_valid);
    bit done;
    done     = 1'b0;
    x_in     = xv;
    w_in     = wv;
    bias_in  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        sb_q.push_back(ref_neuron(xv, wv, b));
        last_accept_cyc = cyc;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check_output("accept_timeout", 0, 1);
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 100 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb_q.size() != 0) check_output("drain_timeout", longint'(sb_q.size()), 0);
  endtask

  initial begin
    logic [OUT_W-1:0] exp_v;
    int lat;
    int prev_acc;
    int sent;
    bit have;
    logic [N_INPUTS*IN_W-1:0] rx;
    logic [N_INPUTS*WT_W-1:0] rw;
    logic [WT_W-1:0] rb;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_in_ready", longint'(in_ready), 1);
    check_output("reset_out_valid", longint'(out_valid), 0);
    check_output("reset_neuron_out", longint'(neuron_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic dot product and the latency from the accept edge.
    apply_stimulus(pack_x(1, 2, 3), pack_w(1, 1, 1), 8'sd0, 1'b0);
    lat = 1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("latency", longint'(lat), N_INPUTS + 1);
    wait_drain();

    // Negative, zero-crossing and positive small results.
    apply_stimulus(pack_x(5, 5, 5), pack_w(-1, -1, -1), 8'sd0, 1'b0);
    wait_drain();
    apply_stimulus(pack_x(10, 0, 0), pack_w(2, 0, 0), -8'sd25, 1'b0);
    wait_drain();
    apply_stimulus(pack_x(10, 0, 0), pack_w(2, 0, 0), -8'sd15, 1'b0);
    wait_drain();
    apply_stimulus(pack_x(10, 0, 0), pack_w(2, 0, 0), -8'sd20, 1'b0);
    wait_drain();
    apply_stimulus(pack_x(1023, 0, 0), pack_w(2, 0, 0), 8'sd1, 1'b0);
    wait_drain();
    apply_stimulus(pack_x(1023, 1023, 1023), pack_w(127, 127, 127), 8'sd127, 1'b0);
    wait_drain();

    // Backpressure: result must be held while out_ready stays low.
    out_ready = 1'b0;
    exp_v = ref_neuron(pack_x(7, 8, 9), pack_w(3, -2, 4), 8'sd5);
    apply_stimulus(pack_x(7, 8, 9), pack_w(3, -2, 4), 8'sd5, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      check_output("hold_out_valid", longint'(out_valid), 1);
      check_output("hold_neuron_out", longint'(neuron_out), longint'(exp_v));
      check_output("hold_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("retire_in_ready", longint'(in_ready), 1);
    check_output("retire_out_valid", longint'(out_valid), 0);
    check_output("retire_neuron_out_held", longint'(neuron_out), longint'(exp_v));
    check_output("retire_scoreboard_empty", longint'(sb_q.size()), 0);

    // Reset in the middle of accumulation discards the operation.
    apply_stimulus(pack_x(1, 2, 3), pack_w(1, 1, 1), 8'sd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    check_output("midreset_in_ready", longint'(in_ready), 1);
    check_output("midreset_out_valid", longint'(out_valid), 0);
    check_output("midreset_neuron_out", longint'(neuron_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    apply_stimulus(pack_x(1, 2, 3), pack_w(1, 1, 1), 8'sd0, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held high and operands changing during MAC.
    prev_acc = 0;
    for (int t = 0; t < 4; t++) begin
      apply_stimulus(pack_x(rand_x(), rand_x(), rand_x()),
                     pack_w(rand_w(), rand_w(), rand_w()), WT_W'(rand_w()), 1'b1);
      if (t > 0) check_output("b2b_spacing", longint'(last_accept_cyc - prev_acc), N_INPUTS + 2);
      prev_acc = last_accept_cyc;
      for (int j = 0; j < 2; j++) begin
        x_in    = pack_x(rand_x(), rand_x(), rand_x());
        w_in    = pack_w(rand_w(), rand_w(), rand_w());
        bias_in = WT_W'(rand_w());
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    wait_drain();

    // Randomized traffic with random gaps and random backpressure.
    sent = 0;
    have = 1'b0;
    rx = '0;
    rw = '0;
    rb = '0;
    for (int c = 0; c < 4000 && (sent < 40 || sb_q.size() != 0); c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!have && sent < 40 && $urandom_range(0, 2) != 0) begin
        rx = pack_x(rand_x(), rand_x(), rand_x());
        rw = pack_w(rand_w(), rand_w(), rand_w());
        rb = WT_W'(rand_w());
        have = 1'b1;
      end
      if (have) begin
        x_in = rx; w_in = rw; bias_in = rb;
      end else begin
        x_in = pack_x(rand_x(), rand_x(), rand_x());
        w_in = pack_w(rand_w(), rand_w(), rand_w());
      end
      in_valid = have;
      if (have && in_ready) begin
        sb_q.push_back(ref_neuron(rx, rw, rb));
        have = 1'b0;
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_output("random_all_accepted", longint'(sent), 40);
    check_output("random_scoreboard_empty", longint'(sb_q.size()), 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
